// File: rtl/ppt_pkg.sv
// ppt_pkg: shared state encoding and widths for the PPT pulse sequencer.
package ppt_pkg;

    localparam int CNT_W = 16;
    localparam int DIV_W = 5;
    localparam int PRE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ppt_prescaler.sv
// ppt_prescaler: 32-bit free-running divider that pulses tick every 2^(clk_div+1) clocks.
module ppt_prescaler #(
    parameter int DIV_W = ppt_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick
);
    import ppt_pkg::*;

    logic [PRE_W-1:0] cnt;
    logic [PRE_W-1:0] term;
    logic [DIV_W-1:0] sh;

    // Terminal value 2^(clk_div+1)-1 is an all-ones mask shifted down, so clk_div=31 needs no 33rd bit.
    always_comb begin
        sh   = DIV_W'(PRE_W - 1) - clk_div;
        term = {PRE_W{1'b1}} >> sh;
        tick = (cnt == term);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else
            cnt <= (clr || tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/ppt_sequencer.sv
// ppt_sequencer: fires a train of count pulses of hi ticks separated by lo ticks on the PPT trigger.
module ppt_sequencer #(
    parameter int CNT_W = ppt_pkg::CNT_W,
    parameter int DIV_W = ppt_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] count,
    input  logic             run_ppt,
    output logic             fire,
    output logic [CNT_W-1:0] count_done,
    output logic             done,
    output logic             busy
);
    import ppt_pkg::*;

    state_t           state, state_d;
    logic [CNT_W-1:0] hi_len, lo_len, cnt_sh, tcnt;
    logic [CNT_W-1:0] hi_calc, lo_calc, cd_inc, tcnt_d, count_done_d;
    logic             done_d, start, phase_end, tick, idle_like;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);

    ppt_prescaler #(.DIV_W(DIV_W)) u_pre (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (idle_like),
        .clk_div (clk_div),
        .tick    (tick)
    );

    always_comb begin
        hi_calc      = (width == '0) ? CNT_W'(1) : width;
        lo_calc      = (period > hi_calc) ? period - hi_calc : CNT_W'(1);
        cd_inc       = count_done + CNT_W'(1);
        start        = (state == ST_IDLE) && run_ppt && (count != '0);
        phase_end    = tick && (tcnt == ((state == ST_HIGH) ? hi_len : lo_len) - CNT_W'(1));
        state_d      = state;
        done_d       = done;
        count_done_d = count_done;
        tcnt_d       = tick ? tcnt + CNT_W'(1) : tcnt;
        case (state)
            ST_IDLE: begin
                tcnt_d = '0;
                if (run_ppt) begin
                    state_d      = start ? ST_HIGH : ST_DONE;
                    done_d       = !start;
                    count_done_d = '0;
                end
            end
            ST_HIGH: begin
                if (!run_ppt) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else if (phase_end) begin
                    count_done_d = cd_inc;
                    tcnt_d       = '0;
                    state_d      = (cd_inc == cnt_sh) ? ST_DONE : ST_LOW;
                    done_d       = (cd_inc == cnt_sh);
                end
            end
            ST_LOW: begin
                if (!run_ppt) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else if (phase_end) begin
                    state_d = ST_HIGH;
                    tcnt_d  = '0;
                end
            end
            default: begin
                tcnt_d = '0;
                if (!run_ppt)
                    state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            fire       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count_done <= '0;
            tcnt       <= '0;
        end else begin
            state      <= state_d;
            fire       <= (state_d == ST_HIGH);
            busy       <= (state_d == ST_HIGH) || (state_d == ST_LOW);
            done       <= done_d;
            count_done <= count_done_d;
            tcnt       <= tcnt_d;
        end
    end

    // Shadow copies make mid-run register writes invisible to the active train.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_len <= CNT_W'(1);
            lo_len <= CNT_W'(1);
            cnt_sh <= '0;
        end else if (start) begin
            hi_len <= hi_calc;
            lo_len <= lo_calc;
            cnt_sh <= count;
        end
    end

endmodule

// File: doc/ppt_sequencer.md
# ppt_sequencer

Pulse sequencer for the pulsed-plasma-thruster (PPT) channel. It takes the clock-divider, period, width, count and run settings from the I2C-accessible register map and drives the thruster trigger with a train of `count` pulses. It reports progress (`count_done`) and completion (`done`) back to the register map's read-only locations. It sits between the register map and the PPT trigger pad.

## Interface

Parameters:
- `CNT_W`, default 16: width of the period, width and count fields and of the tick counters.
- `DIV_W`, default 5: width of `clk_div`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (32.768 kHz oscillator domain)
- `rstn`  in  1  asynchronous active-low reset
- `clk_div`  in  5  prescaler exponent; tick period = 2^(clk_div+1) clocks
- `period`  in  16  pulse repetition period, in ticks
- `width`  in  16  pulse high time, in ticks
- `count`  in  16  number of pulses to fire
- `run_ppt`  in  1  level enable; 1 = start or continue, 0 = stop or abort
- `fire`  out  1  registered PPT trigger output
- `count_done`  out  16  pulses completed in the current or last run
- `done`  out  1  the last run completed all `count` pulses
- `busy`  out  1  state is HIGH or LOW

## Operation

- Reset values: state IDLE, `fire`=0, `count_done`=0, `done`=0, `busy`=0, prescaler=0.
- Prescaler:
  - 32-bit up-counter; asserts a one-clock `tick` when it equals 2^(clk_div+1)−1, then wraps to 0.
  - `clk_div`=31 is legal (terminal value 2^32−1).
  - Held at 0 in IDLE and DONE; cleared on start.
- Configuration is latched into shadow registers at start. Register changes during a run are ignored.
- Phase lengths:
  - hi = max(width,1).
  - lo = period−hi when period>hi, otherwise 1.
  - Computed once at start in 16 bits; no overflow is possible.
- FSM states: IDLE, HIGH, LOW, DONE.
  - IDLE: when `run_ppt`=1:
    - if count≠0: latch config, clear `count_done` and `done`, clear the tick counter, go to HIGH.
    - if count=0: set `done`=1 and go to DONE; `count_done` stays 0.
  - HIGH: `fire`=1. After hi ticks, `count_done`+1. Then:
    - if `count_done`+1 = count: go to DONE and set `done`=1.
    - otherwise go to LOW.
  - LOW: `fire`=0. After lo ticks, go to HIGH.
  - DONE: `fire`=0. When `run_ppt`=0, go to IDLE. `done` and `count_done` hold until the next start.
- Abort: `run_ppt`=0 while in HIGH or LOW.
  - Next state is IDLE and `fire` drops on the next edge.
  - `done` stays 0 and `count_done` holds its value.
- Restart requires `run_ppt` to go 0 and then 1. Holding `run_ppt` high after DONE never retriggers.
- `run_ppt` is synchronous to `clk` (it comes from the register map in the same domain); no synchroniser is needed.

## Timing

- Start: `run_ppt`=1 sampled in IDLE at edge N gives `fire`=1 from edge N+1.
- The high phase lasts exactly hi·2^(clk_div+1) clocks; the low phase lasts exactly lo·2^(clk_div+1) clocks.
- The falling edge of `fire`, the `count_done` increment and (on the last pulse) `done` rising all happen on the same edge.
- The last pulse has no trailing LOW phase.
- `busy` is registered and tracks state with zero extra latency.
- Reset mid-pulse forces `fire`=0 asynchronously; all outputs return to their reset values.

## Structure

- Package `ppt_pkg` holds:
  - the state encoding (IDLE=0, HIGH=1, LOW=2, DONE=3);
  - `CNT_W`, `DIV_W` and the prescaler width (32).
- Sub-module `ppt_prescaler` contains the 32-bit counter, terminal-value compare, clear input and `tick` output.
- All other logic (FSM, shadow registers, tick counter, pulse counter) lives in `ppt_sequencer`.

## Test plan

1. Basic train: clk_div=0, width=1, period=4, count=3, run=1.
   - `fire` high 2 clocks and low 6 clocks, three pulses in total.
   - `count_done` reads 1, 2, 3 on the falling edges.
   - `done`=1 on the third falling edge; state DONE.
2. Abort: clk_div=0, width=2, period=8, count=10; drop run during the 2nd HIGH.
   - `fire`=0 on the next edge; IDLE.
   - `count_done`=1, `done`=0.
3. Degenerate config:
   - count=0 gives `done`=1 one clock after start, no `fire`.
   - width=0, period=0, count=2 gives two pulses of 2 clocks high separated by 2 clocks low.
4. Latching and restart:
   - Change period and count mid-run: the sequence is unaffected.
   - Holding run=1 in DONE causes no retrigger.
   - run 0→1 clears `done` and `count_done` and starts a new train.
5. Reset mid-run: assert rstn=0 while `fire`=1.
   - `fire` drops immediately, without waiting for a clock.
   - `count_done`=0, `done`=0, IDLE after release.
6. Default config: clk_div=9, width=1, period=128, count=16.
   - `fire` high 1024 clocks.
   - Rising edges 131072 clocks apart.
   - `done` after the 16th pulse.
